// File: rtl/pad_serdes_bridge.sv
// pad_serdes_bridge: deserialises a narrow pad bus into core receive words and serialises core decoded words onto a narrow pad bus.
module pad_serdes_bridge #(
  parameter int IN_PINS    = 4,
  parameter int CORE_IN_W  = 16,
  parameter int OUT_PINS   = 2,
  parameter int CORE_OUT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_PINS-1:0]    pad_in,
  input  logic                  pad_in_frame,
  output logic [CORE_IN_W-1:0]  core_data_recv,
  output logic                  core_recv_valid,
  input  logic [CORE_OUT_W-1:0] core_data_dec,
  input  logic                  core_dec_valid,
  output logic                  core_dec_ready,
  output logic [OUT_PINS-1:0]   pad_out,
  output logic                  pad_out_frame,
  output logic                  pad_out_oen,
  output logic                  core_rst_n,
  output logic [7:0]            err_cnt
);
  localparam int IN_BEATS  = CORE_IN_W / IN_PINS;
  localparam int OUT_BEATS = CORE_OUT_W / OUT_PINS;
  localparam int IBW = IN_BEATS > 1 ? $clog2(IN_BEATS) : 1;
  localparam int OBW = OUT_BEATS > 1 ? $clog2(OUT_BEATS) : 1;
  localparam logic [IBW-1:0] IN_LAST  = IBW'(IN_BEATS - 1);
  localparam logic [OBW-1:0] OUT_LAST = OBW'(OUT_BEATS - 1);

  typedef enum logic {D_IDLE, D_COLLECT} d_state_t;
  typedef enum logic {S_IDLE, S_SEND} s_state_t;

  logic [1:0] sync;
  always_ff @(posedge clk or negedge rst)
    if (!rst) sync <= '0;
    else sync <= {sync[0], 1'b1};
  assign core_rst_n = sync[1];

  logic [IN_PINS-1:0] s1_data;
  logic               s1_frame;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1_data  <= '0;
      s1_frame <= 1'b0;
    end else begin
      s1_data  <= pad_in;
      s1_frame <= pad_in_frame;
    end

  d_state_t             d_state, d_next;
  logic [IBW-1:0]       bcnt;
  logic [CORE_IN_W-1:0] rbuf, asm_word;
  logic                 in_last;
  assign in_last = d_state == D_COLLECT && bcnt == IN_LAST;

  always_comb begin
    asm_word = rbuf;
    asm_word[bcnt*IN_PINS +: IN_PINS] = s1_data;
  end

  always_comb begin
    d_next = d_state;
    if (s1_frame) d_next = IN_BEATS == 1 ? D_IDLE : D_COLLECT;
    else if (in_last) d_next = D_IDLE;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) d_state <= D_IDLE;
    else d_state <= d_next;

  // A frame beat always restarts at slice 0; arriving mid-word it also counts as an error.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rbuf            <= '0;
      bcnt            <= '0;
      core_data_recv  <= '0;
      core_recv_valid <= 1'b0;
      err_cnt         <= '0;
    end else begin
      core_recv_valid <= 1'b0;
      if (s1_frame) begin
        if (d_state == D_COLLECT && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        rbuf[IN_PINS-1:0] <= s1_data;
        bcnt <= IN_BEATS > 1 ? IBW'(1) : IBW'(0);
        if (IN_BEATS == 1) begin
          core_data_recv  <= CORE_IN_W'(s1_data);
          core_recv_valid <= 1'b1;
        end
      end else if (d_state == D_COLLECT) begin
        rbuf[bcnt*IN_PINS +: IN_PINS] <= s1_data;
        bcnt <= in_last ? IBW'(0) : bcnt + IBW'(1);
        if (in_last) begin
          core_data_recv  <= asm_word;
          core_recv_valid <= 1'b1;
        end
      end
    end

  s_state_t              s_state, s_next;
  logic [OBW-1:0]        ocnt, ocnt_nxt;
  logic [CORE_OUT_W-1:0] hold;
  logic                  out_last, accept;
  assign out_last       = s_state == S_SEND && ocnt == OUT_LAST;
  assign core_dec_ready = core_rst_n && (s_state == S_IDLE || out_last);
  assign accept         = core_dec_valid && core_dec_ready;
  assign ocnt_nxt       = ocnt + OBW'(1);

  always_comb begin
    s_next = s_state;
    s_next = accept ? S_SEND : out_last ? S_IDLE : s_state;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) s_state <= S_IDLE;
    else s_state <= s_next;

  // Accept on the last beat chains straight into beat 0 of the next word.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hold          <= '0;
      ocnt          <= '0;
      pad_out       <= '0;
      pad_out_frame <= 1'b0;
      pad_out_oen   <= 1'b1;
    end else if (accept) begin
      hold          <= core_data_dec;
      ocnt          <= '0;
      pad_out       <= core_data_dec[OUT_PINS-1:0];
      pad_out_frame <= 1'b1;
      pad_out_oen   <= 1'b0;
    end else if (out_last) begin
      ocnt          <= '0;
      pad_out       <= '0;
      pad_out_frame <= 1'b0;
      pad_out_oen   <= 1'b1;
    end else if (s_state == S_SEND) begin
      ocnt          <= ocnt_nxt;
      pad_out       <= hold[ocnt_nxt*OUT_PINS +: OUT_PINS];
      pad_out_frame <= 1'b0;
    end
endmodule

// File: tb/tb_pad_serdes_bridge.sv
// tb_pad_serdes_bridge: directed vectors for pad_serdes_bridge with default parameters.
module tb_pad_serdes_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  pad_in;
  logic        pad_in_frame;
  logic [15:0] core_data_recv;
  logic        core_recv_valid;
  logic [7:0]  core_data_dec;
  logic        core_dec_valid;
  logic        core_dec_ready;
  logic [1:0]  pad_out;
  logic        pad_out_frame;
  logic        pad_out_oen;
  logic        core_rst_n;
  logic [7:0]  err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  pad_serdes_bridge dut (
    .clk(clk), .rst(rst), .pad_in(pad_in), .pad_in_frame(pad_in_frame),
    .core_data_recv(core_data_recv), .core_recv_valid(core_recv_valid),
    .core_data_dec(core_data_dec), .core_dec_valid(core_dec_valid),
    .core_dec_ready(core_dec_ready), .pad_out(pad_out), .pad_out_frame(pad_out_frame),
    .pad_out_oen(pad_out_oen), .core_rst_n(core_rst_n), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [3:0] d, input logic f);
    pad_in = d;
    pad_in_frame = f;
    step();
  endtask

  logic [1:0] tx_a [4] = '{2'd0, 2'd1, 2'd3, 2'd2};
  logic [1:0] tx_s [8] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1};

  initial begin
    pad_in = '0;
    pad_in_frame = 1'b0;
    core_data_dec = '0;
    core_dec_valid = 1'b0;
    #2 rst = 1'b0;
    repeat (3) step();
    chk("rst_recv", core_data_recv, 0);
    chk("rst_rvalid", core_recv_valid, 0);
    chk("rst_ready", core_dec_ready, 0);
    chk("rst_pad_out", pad_out, 0);
    chk("rst_frame", pad_out_frame, 0);
    chk("rst_oen", pad_out_oen, 1);
    chk("rst_core_rst_n", core_rst_n, 0);
    chk("rst_err", err_cnt, 0);

    core_data_dec = 8'hB4;
    core_dec_valid = 1'b1;
    rst = 1'b1;
    step();
    chk("rel1_core_rst_n", core_rst_n, 0);
    chk("rel1_ready", core_dec_ready, 0);
    chk("rel1_oen", pad_out_oen, 1);
    step();
    chk("rel2_core_rst_n", core_rst_n, 1);
    chk("rel2_ready", core_dec_ready, 1);
    chk("rel2_oen", pad_out_oen, 1);
    step();
    core_dec_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("tx_pad", pad_out, tx_a[i]);
      chk("tx_frame", pad_out_frame, i == 0);
      chk("tx_oen", pad_out_oen, 0);
      chk("tx_ready", core_dec_ready, i == 3);
      step();
    end
    chk("tx_idle_oen", pad_out_oen, 1);
    chk("tx_idle_pad", pad_out, 0);
    chk("tx_idle_frame", pad_out_frame, 0);

    beat(4'h1, 1'b1);
    beat(4'h2, 1'b0);
    beat(4'h3, 1'b0);
    beat(4'h4, 1'b0);
    chk("rx_early_valid", core_recv_valid, 0);
    beat(4'h0, 1'b0);
    chk("rx_valid", core_recv_valid, 1);
    chk("rx_data", core_data_recv, 16'h4321);
    step();
    chk("rx_pulse_end", core_recv_valid, 0);
    chk("rx_hold", core_data_recv, 16'h4321);

    beat(4'h1, 1'b1);
    beat(4'h2, 1'b0);
    beat(4'h3, 1'b0);
    beat(4'h4, 1'b0);
    beat(4'hA, 1'b1);
    chk("b2b_valid1", core_recv_valid, 1);
    chk("b2b_data1", core_data_recv, 16'h4321);
    beat(4'hB, 1'b0);
    chk("b2b_gap1", core_recv_valid, 0);
    beat(4'hC, 1'b0);
    beat(4'hD, 1'b0);
    chk("b2b_gap3", core_recv_valid, 0);
    beat(4'h0, 1'b0);
    chk("b2b_valid2", core_recv_valid, 1);
    chk("b2b_data2", core_data_recv, 16'hDCBA);
    chk("b2b_err", err_cnt, 0);

    beat(4'h1, 1'b1);
    beat(4'h2, 1'b0);
    beat(4'h7, 1'b1);
    beat(4'h8, 1'b0);
    beat(4'h9, 1'b0);
    beat(4'hA, 1'b0);
    beat(4'h0, 1'b0);
    chk("early_valid", core_recv_valid, 1);
    chk("early_data", core_data_recv, 16'hA987);
    chk("early_err", err_cnt, 1);
    for (int r = 0; r < 299; r++) begin
      beat(4'h1, 1'b1);
      beat(4'h2, 1'b0);
      beat(4'h7, 1'b1);
      beat(4'h8, 1'b0);
      beat(4'h9, 1'b0);
      beat(4'hA, 1'b0);
      chk("err_count", err_cnt, (r + 2 > 255) ? 255 : r + 2);
    end
    beat(4'h0, 1'b0);
    chk("sat_valid", core_recv_valid, 1);
    chk("sat_data", core_data_recv, 16'hA987);
    chk("sat_err", err_cnt, 255);

    core_data_dec = 8'hB4;
    core_dec_valid = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      chk("st_pad", pad_out, tx_s[i]);
      chk("st_frame", pad_out_frame, i == 0 || i == 4);
      chk("st_oen", pad_out_oen, 0);
      chk("st_ready", core_dec_ready, i == 3 || i == 7);
      if (i == 0) core_data_dec = 8'h5A;
      if (i == 4) core_dec_valid = 1'b0;
      step();
    end
    chk("st_idle_oen", pad_out_oen, 1);
    chk("st_idle_pad", pad_out, 0);

    core_data_dec = 8'hB4;
    core_dec_valid = 1'b1;
    step();
    core_dec_valid = 1'b0;
    step();
    chk("mid_oen_before", pad_out_oen, 0);
    rst = 1'b0;
    #1;
    chk("mid_oen", pad_out_oen, 1);
    chk("mid_pad", pad_out, 0);
    chk("mid_core_rst_n", core_rst_n, 0);
    chk("mid_ready", core_dec_ready, 0);
    chk("mid_err", err_cnt, 0);
    rst = 1'b1;
    step();
    step();
    chk("mid_rel_core_rst_n", core_rst_n, 1);
    chk("mid_rel_oen", pad_out_oen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
